hdmi_sync_gen: RTL and testbench

- Parametrised successor to the HdmiSync timing generator for the HDMI output path.
- Produces registered dataEnable/hSync/vSync and drives pixel coordinates to the pattern/data block through a setXY ENA/RDY handshake, issued one cycle ahead.
- Adds frame-boundary shadow-register reconfiguration, programmable region thresholds, config validation, a frameStart pulse and a saturating underrun counter.

---
 rtl/hdmi_sync_gen.sv | 275 +++++++++++++++++++++++++++
 tb/tb_hdmi_sync_gen.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_sync_gen.sv
// -----------------------------------------------------------------------------
// hdmi_sync_gen
//
// Purpose:
//   Video timing generator for the HDMI output path. A pair of free-running
//   pixel counters (h, v) walks a programmable frame. Each cycle the current
//   coordinate is offered to the pattern/data block as a setXY request
//   (stage 0, combinational from the counters). The matching dataEnable,
//   hSync, vSync and frameStart outputs are registered and appear one cycle
//   later (stage 1), so the request for pixel (x,y) leads its dataEnable by
//   exactly one cycle.
//
//   Timing configuration is written through a setup port into a shadow
//   register set. It is validated on arrival. A legal configuration is
//   copied into the active set either right away (generator idle) or on the
//   last pixel of the current frame (generator running), so a frame never
//   mixes two configurations.
//
// Optional feature (macro HDMI_SYNC_POLARITY_EN):
//   Defined   : setup_h_pol_i / setup_v_pol_i select sync polarity
//               (1 = active-high). They travel with the rest of the config.
//   Undefined : the polarity inputs are absent; syncs are active-high.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   setup_ena_i / setup_rdy_o    config load request / accept
//   setup_{h,v}_*_i              horizontal / vertical thresholds
//   data_set_xy_ena_o            pixel request (equals running_o)
//   data_set_xy_x_o / _y_o       pixel coordinate of the request
//   data_set_xy_data_enable_o    the requested pixel is an active pixel
//   data_set_xy_rdy_i            downstream ready
//   data_enable_o, h_sync_o,
//   v_sync_o, frame_start_o      registered video timing (stage 1)
//   running_o                    timing active
//   cfg_err_o                    sticky: last setup was rejected
//   underrun_o                   saturating count of missed active pixels
//   dbg_state_o                  generator state (0 = idle, 1 = running)
// -----------------------------------------------------------------------------
module hdmi_sync_gen #(
  parameter int WIDTH_ADDR  = 12,
  parameter int HEIGHT_ADDR = 12,
  parameter int UNDERRUN_W  = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   setup_ena_i,
  input  logic [WIDTH_ADDR-1:0]  setup_h_active_i,
  input  logic [WIDTH_ADDR-1:0]  setup_h_sync_start_i,
  input  logic [WIDTH_ADDR-1:0]  setup_h_sync_end_i,
  input  logic [WIDTH_ADDR-1:0]  setup_h_total_i,
  input  logic [HEIGHT_ADDR-1:0] setup_v_active_i,
  input  logic [HEIGHT_ADDR-1:0] setup_v_sync_start_i,
  input  logic [HEIGHT_ADDR-1:0] setup_v_sync_end_i,
  input  logic [HEIGHT_ADDR-1:0] setup_v_total_i,
`ifdef HDMI_SYNC_POLARITY_EN
  input  logic                   setup_h_pol_i,
  input  logic                   setup_v_pol_i,
`endif
  output logic                   setup_rdy_o,
  output logic                   data_set_xy_ena_o,
  output logic [WIDTH_ADDR-1:0]  data_set_xy_x_o,
  output logic [HEIGHT_ADDR-1:0] data_set_xy_y_o,
  output logic                   data_set_xy_data_enable_o,
  input  logic                   data_set_xy_rdy_i,
  output logic                   data_enable_o,
  output logic                   h_sync_o,
  output logic                   v_sync_o,
  output logic                   frame_start_o,
  output logic                   running_o,
  output logic                   cfg_err_o,
  output logic [UNDERRUN_W-1:0]  underrun_o,
  output logic                   dbg_state_o
);

  // Handshakes: a setup transfer happens on a rising clk edge where
  // setup_ena_i and setup_rdy_o are both 1. The setXY request is offered
  // whenever data_set_xy_ena_o is 1; it completes only if data_set_xy_rdy_i
  // is 1 in that cycle, but the stream never waits -- an active pixel whose
  // request is not taken is counted as an underrun and dropped.

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [WIDTH_ADDR-1:0]  h_active;
    logic [WIDTH_ADDR-1:0]  h_sync_start;
    logic [WIDTH_ADDR-1:0]  h_sync_end;
    logic [WIDTH_ADDR-1:0]  h_total;
    logic [HEIGHT_ADDR-1:0] v_active;
    logic [HEIGHT_ADDR-1:0] v_sync_start;
    logic [HEIGHT_ADDR-1:0] v_sync_end;
    logic [HEIGHT_ADDR-1:0] v_total;
    logic                   h_pol;
    logic                   v_pol;
  } cfg_t;

  state_e                 state_q, state_d;
  cfg_t                   shadow_q, shadow_d;
  cfg_t                   active_q, active_d;
  cfg_t                   setup_cfg;
  logic                   pending_q, pending_d;
  logic                   cfg_err_q, cfg_err_d;
  logic                   setup_rdy_q;
  logic [WIDTH_ADDR-1:0]  h_cnt_q, h_cnt_d;
  logic [HEIGHT_ADDR-1:0] v_cnt_q, v_cnt_d;
  logic [UNDERRUN_W-1:0]  underrun_q, underrun_d;
  logic                   de_q, de_d;
  logic                   hs_q, hs_d;
  logic                   vs_q, vs_d;
  logic                   fs_q, fs_d;

  logic running;
  logic accept;
  logic legal;
  logic apply;
  logic line_end;
  logic frame_end;
  logic de_field;
  logic hs_raw;
  logic vs_raw;

  // Polarity reset value is active-high; without the feature it stays so.
  localparam cfg_t CFG_RESET = '{h_pol: 1'b1, v_pol: 1'b1, default: '0};

  always_comb begin
    setup_cfg              = CFG_RESET;
    setup_cfg.h_active     = setup_h_active_i;
    setup_cfg.h_sync_start = setup_h_sync_start_i;
    setup_cfg.h_sync_end   = setup_h_sync_end_i;
    setup_cfg.h_total      = setup_h_total_i;
    setup_cfg.v_active     = setup_v_active_i;
    setup_cfg.v_sync_start = setup_v_sync_start_i;
    setup_cfg.v_sync_end   = setup_v_sync_end_i;
    setup_cfg.v_total      = setup_v_total_i;
`ifdef HDMI_SYNC_POLARITY_EN
    setup_cfg.h_pol        = setup_h_pol_i;
    setup_cfg.v_pol        = setup_v_pol_i;
`endif
  end

  assign running   = (state_q == ST_RUN);
  assign accept    = setup_ena_i && setup_rdy_q;
  assign legal     = (setup_h_active_i != '0) &&
                     (setup_h_active_i <= setup_h_sync_start_i) &&
                     (setup_h_sync_start_i < setup_h_sync_end_i) &&
                     (setup_h_sync_end_i <= setup_h_total_i) &&
                     (setup_v_active_i != '0) &&
                     (setup_v_active_i <= setup_v_sync_start_i) &&
                     (setup_v_sync_start_i < setup_v_sync_end_i) &&
                     (setup_v_sync_end_i <= setup_v_total_i);

  assign line_end  = (h_cnt_q == active_q.h_total - 1'b1);
  assign frame_end = line_end && (v_cnt_q == active_q.v_total - 1'b1);

  assign de_field  = running && (h_cnt_q < active_q.h_active) &&
                     (v_cnt_q < active_q.v_active);
  assign hs_raw    = (h_cnt_q >= active_q.h_sync_start) &&
                     (h_cnt_q < active_q.h_sync_end);
  assign vs_raw    = (v_cnt_q >= active_q.v_sync_start) &&
                     (v_cnt_q < active_q.v_sync_end);

  // Generator state and config application.
  always_comb begin
    state_d = state_q;
    apply   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          apply   = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // Swap only on the last pixel so the next frame is entirely new.
        if (pending_q && frame_end) begin
          apply = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next-state.
  always_comb begin
    shadow_d   = shadow_q;
    active_d   = active_q;
    pending_d  = pending_q && !apply;
    cfg_err_d  = cfg_err_q;
    h_cnt_d    = h_cnt_q;
    v_cnt_d    = v_cnt_q;
    underrun_d = underrun_q;

    // A setup arriving on the apply cycle lands in the shadow and stays
    // pending; the active set takes the previous shadow contents.
    if (accept) begin
      cfg_err_d = !legal;
      if (legal) begin
        shadow_d  = setup_cfg;
        pending_d = 1'b1;
      end
    end

    if (apply) begin
      active_d = shadow_q;
      h_cnt_d  = '0;
      v_cnt_d  = '0;
    end else if (running) begin
      if (line_end) begin
        h_cnt_d = '0;
        v_cnt_d = (v_cnt_q == active_q.v_total - 1'b1) ? '0 : v_cnt_q + 1'b1;
      end else begin
        h_cnt_d = h_cnt_q + 1'b1;
      end
    end

    if (de_field && !data_set_xy_rdy_i && !(&underrun_q)) begin
      underrun_d = underrun_q + 1'b1;
    end

    // Stage 1 is computed from the counters before they advance.
    de_d = de_field;
    hs_d = running && (hs_raw ^ ~active_q.h_pol);
    vs_d = running && (vs_raw ^ ~active_q.v_pol);
    fs_d = running && (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      shadow_q    <= CFG_RESET;
      active_q    <= CFG_RESET;
      pending_q   <= 1'b0;
      cfg_err_q   <= 1'b0;
      setup_rdy_q <= 1'b0;
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      underrun_q  <= '0;
      de_q        <= 1'b0;
      hs_q        <= 1'b0;
      vs_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      cfg_err_q   <= cfg_err_d;
      setup_rdy_q <= 1'b1;
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      underrun_q  <= underrun_d;
      de_q        <= de_d;
      hs_q        <= hs_d;
      vs_q        <= vs_d;
      fs_q        <= fs_d;
    end
  end

  assign setup_rdy_o               = setup_rdy_q;
  assign data_set_xy_ena_o         = running;
  assign data_set_xy_x_o           = h_cnt_q;
  assign data_set_xy_y_o           = v_cnt_q;
  assign data_set_xy_data_enable_o = de_field;
  assign data_enable_o             = de_q;
  assign h_sync_o                  = hs_q;
  assign v_sync_o                  = vs_q;
  assign frame_start_o             = fs_q;
  assign running_o                 = running;
  assign cfg_err_o                 = cfg_err_q;
  assign underrun_o                = underrun_q;
  assign dbg_state_o               = state_q;

endmodule

// File: tb/tb_hdmi_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_hdmi_sync_gen
//
// Directed bench for hdmi_sync_gen. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge. Sample index s
// counts falling edges from the first cycle in which the basic frame runs,
// so at sample s the setXY request shows pixel s mod 40 (basic 8x5 frame)
// and the registered outputs show pixel s-1.
// A second instance with UNDERRUN_W=3 shares all inputs to check saturation.
// -----------------------------------------------------------------------------
module tb_hdmi_sync_gen;

  localparam int WA = 12;
  localparam int HA = 12;

  logic          clk = 1'b0;
  logic          rst;
  logic          setup_ena;
  logic [WA-1:0] h_act, h_ss, h_se, h_tot;
  logic [HA-1:0] v_act, v_ss, v_se, v_tot;
  logic          xy_rdy;
`ifdef HDMI_SYNC_POLARITY_EN
  logic          h_pol, v_pol;
`endif

  logic          setup_rdy, xy_ena, xy_de, de, hs, vs, fs, running, cfg_err;
  logic [WA-1:0] xy_x;
  logic [HA-1:0] xy_y;
  logic [15:0]   underrun;
  logic          dbg_state;

  logic          d3_setup_rdy, d3_xy_ena, d3_xy_de, d3_de, d3_hs, d3_vs;
  logic          d3_fs, d3_running, d3_cfg_err, d3_dbg_state;
  logic [WA-1:0] d3_x;
  logic [HA-1:0] d3_y;
  logic [2:0]    d3_underrun;

  int n_vec = 0;
  int n_err = 0;
  int s     = 0;

  always #5 clk = ~clk;

  hdmi_sync_gen #(.WIDTH_ADDR(WA), .HEIGHT_ADDR(HA), .UNDERRUN_W(16)) u_dut (
    .clk_i(clk), .rst_i(rst), .setup_ena_i(setup_ena),
    .setup_h_active_i(h_act), .setup_h_sync_start_i(h_ss),
    .setup_h_sync_end_i(h_se), .setup_h_total_i(h_tot),
    .setup_v_active_i(v_act), .setup_v_sync_start_i(v_ss),
    .setup_v_sync_end_i(v_se), .setup_v_total_i(v_tot),
`ifdef HDMI_SYNC_POLARITY_EN
    .setup_h_pol_i(h_pol), .setup_v_pol_i(v_pol),
`endif
    .setup_rdy_o(setup_rdy), .data_set_xy_ena_o(xy_ena),
    .data_set_xy_x_o(xy_x), .data_set_xy_y_o(xy_y),
    .data_set_xy_data_enable_o(xy_de), .data_set_xy_rdy_i(xy_rdy),
    .data_enable_o(de), .h_sync_o(hs), .v_sync_o(vs),
    .frame_start_o(fs), .running_o(running), .cfg_err_o(cfg_err),
    .underrun_o(underrun), .dbg_state_o(dbg_state)
  );

  hdmi_sync_gen #(.WIDTH_ADDR(WA), .HEIGHT_ADDR(HA), .UNDERRUN_W(3)) u_dut3 (
    .clk_i(clk), .rst_i(rst), .setup_ena_i(setup_ena),
    .setup_h_active_i(h_act), .setup_h_sync_start_i(h_ss),
    .setup_h_sync_end_i(h_se), .setup_h_total_i(h_tot),
    .setup_v_active_i(v_act), .setup_v_sync_start_i(v_ss),
    .setup_v_sync_end_i(v_se), .setup_v_total_i(v_tot),
`ifdef HDMI_SYNC_POLARITY_EN
    .setup_h_pol_i(h_pol), .setup_v_pol_i(v_pol),
`endif
    .setup_rdy_o(d3_setup_rdy), .data_set_xy_ena_o(d3_xy_ena),
    .data_set_xy_x_o(d3_x), .data_set_xy_y_o(d3_y),
    .data_set_xy_data_enable_o(d3_xy_de), .data_set_xy_rdy_i(xy_rdy),
    .data_enable_o(d3_de), .h_sync_o(d3_hs), .v_sync_o(d3_vs),
    .frame_start_o(d3_fs), .running_o(d3_running), .cfg_err_o(d3_cfg_err),
    .underrun_o(d3_underrun), .dbg_state_o(d3_dbg_state)
  );

  typedef struct {
    int            s;
    logic          ena;
    logic [WA-1:0] x;
    logic [HA-1:0] y;
    logic          sde;
    logic          de;
    logic          hs;
    logic          vs;
    logic          fs;
  } vec_t;

  vec_t tbl[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at s=%0d: got %0d, expected %0d", name, s, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    s++;
  endtask

  task automatic tick_to(input int target);
    while (s < target) tick();
  endtask

  task automatic drive_cfg(input logic [WA-1:0] ha, hss, hse, ht,
                           input logic [HA-1:0] va, vss, vse, vt);
    setup_ena = 1'b1;
    h_act = ha; h_ss = hss; h_se = hse; h_tot = ht;
    v_act = va; v_ss = vss; v_se = vse; v_tot = vt;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_setup_rdy"}, setup_rdy, 0);
    chk({tag, "_xy_ena"},    xy_ena,    0);
    chk({tag, "_x"},         xy_x,      0);
    chk({tag, "_y"},         xy_y,      0);
    chk({tag, "_xy_de"},     xy_de,     0);
    chk({tag, "_de"},        de,        0);
    chk({tag, "_hs"},        hs,        0);
    chk({tag, "_vs"},        vs,        0);
    chk({tag, "_fs"},        fs,        0);
    chk({tag, "_running"},   running,   0);
    chk({tag, "_cfg_err"},   cfg_err,   0);
    chk({tag, "_underrun"},  underrun,  0);
    chk({tag, "_underrun3"}, d3_underrun, 0);
  endtask

  initial begin
    int k;
    int de_cnt;
    int fs_cnt;

    //            s   ena x  y  sde de hs vs fs
    tbl[0]  = '{ 0,  1, 0, 0, 1,  0, 0, 0, 0};
    tbl[1]  = '{ 1,  1, 1, 0, 1,  1, 0, 0, 1};
    tbl[2]  = '{ 4,  1, 4, 0, 0,  1, 0, 0, 0};
    tbl[3]  = '{ 5,  1, 5, 0, 0,  0, 0, 0, 0};
    tbl[4]  = '{ 6,  1, 6, 0, 0,  0, 1, 0, 0};
    tbl[5]  = '{ 7,  1, 7, 0, 0,  0, 0, 0, 0};
    tbl[6]  = '{ 8,  1, 0, 1, 1,  0, 0, 0, 0};
    tbl[7]  = '{ 9,  1, 1, 1, 1,  1, 0, 0, 0};
    tbl[8]  = '{16,  1, 0, 2, 0,  0, 0, 0, 0};
    tbl[9]  = '{17,  1, 1, 2, 0,  0, 0, 0, 0};
    tbl[10] = '{25,  1, 1, 3, 0,  0, 0, 1, 0};
    tbl[11] = '{30,  1, 6, 3, 0,  0, 1, 1, 0};
    tbl[12] = '{32,  1, 0, 4, 0,  0, 0, 1, 0};
    tbl[13] = '{33,  1, 1, 4, 0,  0, 0, 0, 0};
    tbl[14] = '{40,  1, 0, 0, 1,  0, 0, 0, 0};
    tbl[15] = '{41,  1, 1, 0, 1,  1, 0, 0, 1};

    rst = 1'b1; setup_ena = 1'b0; xy_rdy = 1'b1;
    h_act = '0; h_ss = '0; h_se = '0; h_tot = '0;
    v_act = '0; v_ss = '0; v_se = '0; v_tot = '0;
`ifdef HDMI_SYNC_POLARITY_EN
    h_pol = 1'b1; v_pol = 1'b1;
`endif

    // Reset: two rising edges with rst high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    chk("rdy_after_reset", setup_rdy, 1);
    chk("idle_running", running, 0);

    // Illegal config: hSyncStart < hActive.
    drive_cfg(4, 3, 6, 8, 2, 3, 4, 5);
    @(negedge clk);
    setup_ena = 1'b0;
    chk("illegal_cfg_err", cfg_err, 1);
    chk("illegal_running", running, 0);
    @(negedge clk);
    chk("illegal_still_idle", running, 0);
    chk("illegal_err_sticky", cfg_err, 1);

    // Legal basic config clears the error and starts the frame.
    drive_cfg(4, 5, 6, 8, 2, 3, 4, 5);
    @(negedge clk);
    setup_ena = 1'b0;
    chk("legal_cfg_err", cfg_err, 0);
    chk("legal_pending_running", running, 0);
    @(negedge clk);
    s = 0;

    // Basic frame from the vector table, plus per-frame counts.
    k = 0; de_cnt = 0; fs_cnt = 0;
    while (s <= 41) begin
      if (s >= 1 && s <= 40) begin
        de_cnt += int'(de);
        fs_cnt += int'(fs);
      end
      if (k < 16 && tbl[k].s == s) begin
        chk("tbl_ena", xy_ena, tbl[k].ena);
        chk("tbl_x",   xy_x,   tbl[k].x);
        chk("tbl_y",   xy_y,   tbl[k].y);
        chk("tbl_sde", xy_de,  tbl[k].sde);
        chk("tbl_de",  de,     tbl[k].de);
        chk("tbl_hs",  hs,     tbl[k].hs);
        chk("tbl_vs",  vs,     tbl[k].vs);
        chk("tbl_fs",  fs,     tbl[k].fs);
        k++;
      end
      if (s < 41) tick();
      else break;
    end
    chk("frame_de_count", de_cnt, 8);
    chk("frame_fs_count", fs_cnt, 1);
    chk("no_underrun_rdy1", underrun, 0);

    // Underrun: ready low for two full frames starting at pixel (0,0).
    tick_to(80);
    xy_rdy = 1'b0;
    tick_to(120);
    chk("underrun_1frame", underrun, 8);
    chk("underrun3_sat", d3_underrun, 7);
    tick_to(160);
    chk("underrun_2frames", underrun, 16);
    chk("underrun3_sat2", d3_underrun, 7);
    chk("no_stall_x", xy_x, 0);
    chk("no_stall_y", xy_y, 0);
    xy_rdy = 1'b1;

    // Mid-frame reconfig to hTotal=10 at hCount=3 of line 1.
    tick_to(171);
    chk("reconf_pos_x", xy_x, 3);
    chk("reconf_pos_y", xy_y, 1);
    drive_cfg(4, 5, 6, 10, 2, 3, 4, 5);
    tick();
    setup_ena = 1'b0;
    fs_cnt = int'(fs);
    while (s < 200) begin
      tick();
      fs_cnt += int'(fs);
    end
    chk("reconf_no_early_fs", fs_cnt, 0);
    tick();
    chk("reconf_fs_after40", fs, 1);
    tick_to(208);
    chk("new_cfg_x8", xy_x, 8);
    chk("new_cfg_y0", xy_y, 0);
    tick_to(210);
    chk("new_cfg_wrap_x", xy_x, 0);
    chk("new_cfg_wrap_y", xy_y, 1);
    fs_cnt = 0;
    while (s < 250) begin
      tick();
      fs_cnt += int'(fs);
    end
    chk("new_frame_no_fs", fs_cnt, 0);
    tick();
    chk("new_frame_fs_after50", fs, 1);

    // Reset mid-frame at vCount=2.
    tick_to(272);
    chk("pre_reset_y", xy_y, 2);
    rst = 1'b1;
    tick();
    chk_all_zero("midreset");
    rst = 1'b0;
    tick();
    chk("post_reset_rdy", setup_rdy, 1);
    chk("post_reset_idle", running, 0);
    drive_cfg(4, 5, 6, 8, 2, 3, 4, 5);
    tick();
    setup_ena = 1'b0;
    chk("restart_pending", running, 0);
    tick();
    chk("restart_ena", xy_ena, 1);
    chk("restart_x", xy_x, 0);
    chk("restart_y", xy_y, 0);
    tick();
    chk("restart_fs", fs, 1);
    chk("restart_de", de, 1);
    tick_to(s + 7);
    chk("restart_line1_x", xy_x, 0);
    chk("restart_line1_y", xy_y, 1);

`ifdef HDMI_SYNC_POLARITY_EN
    // Active-low syncs.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    h_pol = 1'b0; v_pol = 1'b0;
    drive_cfg(4, 5, 6, 8, 2, 3, 4, 5);
    tick();
    setup_ena = 1'b0;
    tick();
    s = 0;
    tick();
    chk("pol_hs_idle", hs, 1);
    chk("pol_vs_idle", vs, 1);
    tick_to(5);
    chk("pol_hs_pix4", hs, 1);
    tick_to(6);
    chk("pol_hs_pix5", hs, 0);
    tick_to(25);
    chk("pol_vs_line3", vs, 0);
    tick_to(33);
    chk("pol_vs_line4", vs, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
